// File: rtl/fht_seq_ctrl.sv
// fht_seq_ctrl: stage sequencer for a radix-2 FHT engine built around one
// fht_but instance, using ping-pong data banks and a sin/cos ROM.
//
// Parameters:
//   LOG2_N  log2 of the transform size (N = 2^LOG2_N, must be >= 2)
//   WB_LAT  cycles from x1/x2/ROM issue to butterfly result (>= 1)
//   STG_W   stage counter width, 2^STG_W >= LOG2_N
//
// Ports:
//   iCLK, iRESET    clock (rising edge), asynchronous active-low reset
//   iSTART          start pulse, honoured only while idle and not in oDONE
//   oBUSY, oDONE    transform in progress / one-cycle completion pulse
//   oSTAGE, oBANK   current stage, read bank (the write bank is ~oBANK)
//   oRD_EN_12       strobe for oRD_ADDR_1, oRD_ADDR_2 and oROM_ADDR
//   oRD_EN_0        strobe for oRD_ADDR_0, one cycle after the x1/x2 read
//   oWR_EN          strobe for oWR_ADDR_0/1, WB_LAT cycles after the issue
//
// Build option: define FHT_CTRL_BITREV_EN to bit-reverse the stage-0 read
// addresses, so that naturally ordered input is consumed in place.

module fht_seq_ctrl #(
    parameter int LOG2_N = 10,
    parameter int WB_LAT = 3,
    parameter int STG_W  = 4
) (
    input  logic              iCLK,
    input  logic              iRESET,
    input  logic              iSTART,
    output logic              oBUSY,
    output logic              oDONE,
    output logic [STG_W-1:0]  oSTAGE,
    output logic              oBANK,
    output logic              oRD_EN_12,
    output logic [LOG2_N-1:0] oRD_ADDR_1,
    output logic [LOG2_N-1:0] oRD_ADDR_2,
    output logic [LOG2_N-2:0] oROM_ADDR,
    output logic              oRD_EN_0,
    output logic [LOG2_N-1:0] oRD_ADDR_0,
    output logic              oWR_EN,
    output logic [LOG2_N-1:0] oWR_ADDR_0,
    output logic [LOG2_N-1:0] oWR_ADDR_1
);

    localparam int AW = LOG2_N;
    localparam int DW = (WB_LAT > 1) ? $clog2(WB_LAT) : 1;
    localparam logic [STG_W-1:0] LAST_S = STG_W'(LOG2_N - 1);
    localparam logic [DW-1:0]    LAST_D = DW'(WB_LAT - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } state_t;

    state_t           r_state;
    logic [AW-1:0]    r_k;
    logic [AW-1:0]    r_g;
    logic [STG_W-1:0] r_s;
    logic [DW-1:0]    r_d;

    // Issue-cycle x0 in read form, plus natural x0/x1 for the write path.
    logic [AW-1:0]    r_x0_rd;
    logic [AW-1:0]    r_x0;
    logic [AW-1:0]    r_x1;

    logic             r_wb_en [WB_LAT];
    logic [AW-1:0]    r_wb_a0 [WB_LAT];
    logic [AW-1:0]    r_wb_a1 [WB_LAT];

    state_t           w_nxt_state;
    logic [AW-1:0]    w_nxt_k;
    logic [AW-1:0]    w_nxt_g;
    logic [STG_W-1:0] w_nxt_s;
    logic [DW-1:0]    w_nxt_d;
    logic             w_nxt_bank;
    logic             w_issue;
    logic             w_done;

    logic [AW-1:0]    w_h;
    logic [AW-1:0]    w_hm1;
    logic             w_last_k;
    logic             w_last;

    // Current butterfly is the last of the stage when k = H-1 and g is the
    // final group, i.e. g | (2H-1) is all ones.
    assign w_h      = AW'(1) << r_s;
    assign w_hm1    = w_h - AW'(1);
    assign w_last_k = (r_k == w_hm1);
    assign w_last   = w_last_k && ((r_g | w_h | w_hm1) == '1);

    always_comb begin
        w_nxt_state = r_state;
        w_nxt_k     = r_k;
        w_nxt_g     = r_g;
        w_nxt_s     = r_s;
        w_nxt_d     = r_d;
        w_nxt_bank  = oBANK;
        w_issue     = 1'b0;
        w_done      = 1'b0;
        unique case (r_state)
            IDLE: begin
                // The oDONE cycle is still IDLE but must not accept a start.
                if (iSTART && !oDONE) begin
                    w_nxt_state = RUN;
                    w_nxt_k     = '0;
                    w_nxt_g     = '0;
                    w_nxt_s     = '0;
                    w_nxt_bank  = 1'b0;
                    w_issue     = 1'b1;
                end
            end
            RUN: begin
                if (w_last) begin
                    w_nxt_state = DRAIN;
                    w_nxt_d     = '0;
                end else begin
                    w_issue = 1'b1;
                    if (w_last_k) begin
                        w_nxt_k = '0;
                        w_nxt_g = r_g + (w_h << 1);
                    end else begin
                        w_nxt_k = r_k + AW'(1);
                    end
                end
            end
            DRAIN: begin
                if (r_d != LAST_D) begin
                    w_nxt_d = r_d + DW'(1);
                end else if (r_s == LAST_S) begin
                    w_nxt_state = IDLE;
                    w_done      = 1'b1;
                end else begin
                    w_nxt_state = RUN;
                    w_nxt_s     = r_s + STG_W'(1);
                    w_nxt_k     = '0;
                    w_nxt_g     = '0;
                    w_nxt_bank  = ~oBANK;
                    w_issue     = 1'b1;
                end
            end
            default: w_nxt_state = IDLE;
        endcase
    end

    // Addresses of the butterfly about to be presented on the outputs.
    logic [AW-1:0]    w_nh;
    logic [AW-1:0]    w_nx0;
    logic [AW-1:0]    w_nx1;
    logic [AW-1:0]    w_nx2;
    logic [AW-1:0]    w_nr0;
    logic [AW-1:0]    w_nr1;
    logic [AW-1:0]    w_nr2;
    logic [STG_W-1:0] w_rsh;
    logic [AW-2:0]    w_nrom;

    assign w_nh  = AW'(1) << w_nxt_s;
    assign w_nx0 = w_nxt_g + w_nxt_k;
    assign w_nx1 = w_nx0 + w_nh;
    // (H-k) mod H: zero for k = 0, so x2 collapses onto x1.
    assign w_nx2 = w_nxt_g + w_nh +
                   ((w_nxt_k == '0) ? AW'(0) : (w_nh - w_nxt_k));
    // k < H <= N/2, so k always fits the narrower ROM index.
    assign w_rsh  = LAST_S - w_nxt_s;
    assign w_nrom = w_nxt_k[AW-2:0] << w_rsh;

`ifdef FHT_CTRL_BITREV_EN
    function automatic logic [AW-1:0] bitrev(input logic [AW-1:0] a);
        for (int i = 0; i < AW; i++) begin
            bitrev[i] = a[AW-1-i];
        end
    endfunction

    logic w_brev;
    assign w_brev = (w_nxt_s == '0);
    assign w_nr0  = w_brev ? bitrev(w_nx0) : w_nx0;
    assign w_nr1  = w_brev ? bitrev(w_nx1) : w_nx1;
    assign w_nr2  = w_brev ? bitrev(w_nx2) : w_nx2;
`else
    assign w_nr0 = w_nx0;
    assign w_nr1 = w_nx1;
    assign w_nr2 = w_nx2;
`endif

    always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET) begin
            r_state    <= IDLE;
            r_k        <= '0;
            r_g        <= '0;
            r_s        <= '0;
            r_d        <= '0;
            r_x0_rd    <= '0;
            r_x0       <= '0;
            r_x1       <= '0;
            oBUSY      <= 1'b0;
            oDONE      <= 1'b0;
            oSTAGE     <= '0;
            oBANK      <= 1'b0;
            oRD_EN_12  <= 1'b0;
            oRD_ADDR_1 <= '0;
            oRD_ADDR_2 <= '0;
            oROM_ADDR  <= '0;
            oRD_EN_0   <= 1'b0;
            oRD_ADDR_0 <= '0;
            for (int i = 0; i < WB_LAT; i++) begin
                r_wb_en[i] <= 1'b0;
                r_wb_a0[i] <= '0;
                r_wb_a1[i] <= '0;
            end
        end else begin
            r_state    <= w_nxt_state;
            r_k        <= w_nxt_k;
            r_g        <= w_nxt_g;
            r_s        <= w_nxt_s;
            r_d        <= w_nxt_d;
            oBUSY      <= (w_nxt_state != IDLE);
            oDONE      <= w_done;
            oSTAGE     <= w_nxt_s;
            oBANK      <= w_nxt_bank;
            oRD_EN_12  <= w_issue;
            oRD_ADDR_1 <= w_nr1;
            oRD_ADDR_2 <= w_nr2;
            oROM_ADDR  <= w_nrom;
            r_x0_rd    <= w_nr0;
            r_x0       <= w_nx0;
            r_x1       <= w_nx1;
            // x0 enters the butterfly one cycle after x1/x2.
            oRD_EN_0   <= oRD_EN_12;
            oRD_ADDR_0 <= r_x0_rd;
            r_wb_en[0] <= oRD_EN_12;
            r_wb_a0[0] <= r_x0;
            r_wb_a1[0] <= r_x1;
            for (int i = 1; i < WB_LAT; i++) begin
                r_wb_en[i] <= r_wb_en[i-1];
                r_wb_a0[i] <= r_wb_a0[i-1];
                r_wb_a1[i] <= r_wb_a1[i-1];
            end
        end
    end

    assign oWR_EN     = r_wb_en[WB_LAT-1];
    assign oWR_ADDR_0 = r_wb_a0[WB_LAT-1];
    assign oWR_ADDR_1 = r_wb_a1[WB_LAT-1];

endmodule

// File: tb/tb_fht_seq_ctrl.sv
// tb_fht_seq_ctrl: scoreboard bench for fht_seq_ctrl at N=8, WB_LAT=3.
// Expected schedules come from the stage/group/offset rules, per cycle.
`timescale 1ns/1ps
module tb_fht_seq_ctrl;

    localparam int L    = 3;
    localparam int N    = 1 << L;
    localparam int W    = 3;
    localparam int SW   = 4;
    localparam int SPAN = N / 2 + W;
    localparam int T    = L * SPAN;

    logic          iCLK   = 1'b0;
    logic          iRESET = 1'b0;
    logic          iSTART = 1'b0;
    logic          oBUSY;
    logic          oDONE;
    logic [SW-1:0] oSTAGE;
    logic          oBANK;
    logic          oRD_EN_12;
    logic [L-1:0]  oRD_ADDR_1;
    logic [L-1:0]  oRD_ADDR_2;
    logic [L-2:0]  oROM_ADDR;
    logic          oRD_EN_0;
    logic [L-1:0]  oRD_ADDR_0;
    logic          oWR_EN;
    logic [L-1:0]  oWR_ADDR_0;
    logic [L-1:0]  oWR_ADDR_1;

    fht_seq_ctrl #(
        .LOG2_N(L),
        .WB_LAT(W),
        .STG_W (SW)
    ) dut (
        .iCLK      (iCLK),
        .iRESET    (iRESET),
        .iSTART    (iSTART),
        .oBUSY     (oBUSY),
        .oDONE     (oDONE),
        .oSTAGE    (oSTAGE),
        .oBANK     (oBANK),
        .oRD_EN_12 (oRD_EN_12),
        .oRD_ADDR_1(oRD_ADDR_1),
        .oRD_ADDR_2(oRD_ADDR_2),
        .oROM_ADDR (oROM_ADDR),
        .oRD_EN_0  (oRD_EN_0),
        .oRD_ADDR_0(oRD_ADDR_0),
        .oWR_EN    (oWR_EN),
        .oWR_ADDR_0(oWR_ADDR_0),
        .oWR_ADDR_1(oWR_ADDR_1)
    );

    always #5 iCLK = ~iCLK;

    typedef struct {
        int cyc;
        int stg;
        int bank;
        int a1;
        int a2;
        int rom;
    } rd_t;

    typedef struct {
        int cyc;
        int a0;
    } r0_t;

    typedef struct {
        int cyc;
        int w0;
        int w1;
    } wr_t;

    rd_t rd_q[$];
    r0_t r0_q[$];
    wr_t wr_q[$];
    int  done_q[$];

    int cyc       = 0;
    int n_chk     = 0;
    int n_fail    = 0;
    int free_from = 0;
    int busy_from = 1;
    int busy_to   = 0;
    int busy_cnt  = 0;
    int done_seen = 0;
    int last_p0   = 0;

    always @(posedge iCLK) cyc++;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %0d expected %0d",
                     nm, cyc, act, exp);
        end
    endtask

    function automatic int rev(input int x);
        int r;
        r = 0;
        for (int i = 0; i < L; i++) begin
            if (x[i]) r |= 1 << (L - 1 - i);
        end
        return r;
    endfunction

    function automatic int rdform(input int s, input int x);
`ifdef FHT_CTRL_BITREV_EN
        return (s == 0) ? rev(x) : x;
`else
        return (s < 0) ? rev(x) : x;
`endif
    endfunction

    // Full expected schedule of one transform whose first issue is cycle p0.
    task automatic accept(input int p0);
        int t;
        int h;
        int x0;
        int x1;
        int x2;
        int rom;
        for (int s = 0; s < L; s++) begin
            h = 1 << s;
            t = p0 + s * SPAN;
            for (int g = 0; g < N; g += 2 * h) begin
                for (int k = 0; k < h; k++) begin
                    x0  = g + k;
                    x1  = g + h + k;
                    x2  = g + h + ((h - k) % h);
                    rom = k << (L - 1 - s);
                    rd_q.push_back('{t, s, s % 2, rdform(s, x1),
                                     rdform(s, x2), rom});
                    r0_q.push_back('{t + 1, rdform(s, x0)});
                    wr_q.push_back('{t + W, x0, x1});
                    t++;
                end
            end
        end
        done_q.push_back(p0 + T);
        busy_from = p0;
        busy_to   = p0 + T - 1;
        free_from = p0 + T + 2;
        last_p0   = p0;
    endtask

    // Drive iSTART for the next rising edge and predict whether it is taken.
    task automatic step(input logic st);
        @(posedge iCLK);
        #1;
        iSTART = st;
        if (st && iRESET && (cyc + 1) >= free_from) accept(cyc + 1);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_busy"},  int'(oBUSY), 0);
        chk({tag, "_done"},  int'(oDONE), 0);
        chk({tag, "_stage"}, int'(oSTAGE), 0);
        chk({tag, "_bank"},  int'(oBANK), 0);
        chk({tag, "_en12"},  int'(oRD_EN_12), 0);
        chk({tag, "_ra1"},   int'(oRD_ADDR_1), 0);
        chk({tag, "_ra2"},   int'(oRD_ADDR_2), 0);
        chk({tag, "_rom"},   int'(oROM_ADDR), 0);
        chk({tag, "_en0"},   int'(oRD_EN_0), 0);
        chk({tag, "_ra0"},   int'(oRD_ADDR_0), 0);
        chk({tag, "_wen"},   int'(oWR_EN), 0);
        chk({tag, "_wa0"},   int'(oWR_ADDR_0), 0);
        chk({tag, "_wa1"},   int'(oWR_ADDR_1), 0);
    endtask

    // Monitor: per cycle, each strobe must match whether the scoreboard
    // holds an entry due now; matching entries are popped and compared.
    always @(negedge iCLK) begin
        rd_t e;
        r0_t e0;
        wr_t ew;
        bit  due;
        if (!iRESET) begin
            busy_cnt = 0;
        end else begin
            if (oBUSY) busy_cnt++;
            chk("busy", int'(oBUSY),
                int'(cyc >= busy_from && cyc <= busy_to));

            due = (rd_q.size() > 0) && (rd_q[0].cyc == cyc);
            chk("rd_en_12", int'(oRD_EN_12), int'(due));
            if (due) begin
                e = rd_q.pop_front();
                if (oRD_EN_12) begin
                    chk("stage", int'(oSTAGE), e.stg);
                    chk("bank", int'(oBANK), e.bank);
                    chk("rd_addr_1", int'(oRD_ADDR_1), e.a1);
                    chk("rd_addr_2", int'(oRD_ADDR_2), e.a2);
                    chk("rom_addr", int'(oROM_ADDR), e.rom);
                end
            end

            due = (r0_q.size() > 0) && (r0_q[0].cyc == cyc);
            chk("rd_en_0", int'(oRD_EN_0), int'(due));
            if (due) begin
                e0 = r0_q.pop_front();
                if (oRD_EN_0) chk("rd_addr_0", int'(oRD_ADDR_0), e0.a0);
            end

            due = (wr_q.size() > 0) && (wr_q[0].cyc == cyc);
            chk("wr_en", int'(oWR_EN), int'(due));
            if (due) begin
                ew = wr_q.pop_front();
                if (oWR_EN) begin
                    chk("wr_addr_0", int'(oWR_ADDR_0), ew.w0);
                    chk("wr_addr_1", int'(oWR_ADDR_1), ew.w1);
                end
            end

            due = (done_q.size() > 0) && (done_q[0] == cyc);
            chk("done", int'(oDONE), int'(due));
            if (due) void'(done_q.pop_front());
            if (oDONE) begin
                done_seen++;
                chk("busy_len", busy_cnt, T);
                busy_cnt = 0;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        int p;

        repeat (3) @(posedge iCLK);
        #1;
        chk_zero("reset");
        iRESET    = 1'b1;
        free_from = cyc + 1;

        step(1'b1);
        step(1'b0);
        repeat (T + 5) step(1'b0);

        d0 = done_seen;
        repeat (30) step(1'b1);
        repeat (40) step(1'b0);
        chk("held_start_runs", done_seen - d0, 2);

        repeat (300) step(1'($urandom_range(0, 7) == 0));
        repeat (T + 10) step(1'b0);

        step(1'b1);
        p = last_p0;
        while (cyc < p + SPAN + 1) step(1'b0);
        chk("stage_before_reset", int'(oSTAGE), 1);
        #1;
        iRESET = 1'b0;
        #1;
        chk_zero("midreset");
        rd_q.delete();
        r0_q.delete();
        wr_q.delete();
        done_q.delete();
        busy_to   = busy_from - 1;
        free_from = 32'h7fff_ffff;
        repeat (3) @(posedge iCLK);
        #1;
        iRESET    = 1'b1;
        free_from = cyc + 1;

        d0 = done_seen;
        step(1'b1);
        repeat (T + 5) step(1'b0);
        chk("post_reset_runs", done_seen - d0, 1);

        chk("rd_q_left", rd_q.size(), 0);
        chk("r0_q_left", r0_q.size(), 0);
        chk("wr_q_left", wr_q.size(), 0);
        chk("done_q_left", done_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
